// File: rtl/debug_slave_jtag_driver_if.sv
// Command/response bundle for the debug slave JTAG driver.
// Ports: cmd_valid/cmd_ready/cmd_ir/cmd_data in, rsp_valid/rsp_data out.
interface debug_slave_jtag_driver_if #(
   parameter int SR_WIDTH = 38,
   parameter int IR_WIDTH = 2
);
   logic                cmd_valid;
   logic                cmd_ready;
   logic [IR_WIDTH-1:0] cmd_ir;
   logic [SR_WIDTH-1:0] cmd_data;
   logic                rsp_valid;
   logic [SR_WIDTH-1:0] rsp_data;

   // master issues commands, slave is the driver itself
   modport master (
      output cmd_valid, cmd_ir, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_ir, cmd_data,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/debug_slave_jtag_driver.sv
// Host-side virtual JTAG sequencer for the CPU debug slave (2-bit IR).
// Ports: clk, reset (sync, active-high), bus (cmd/rsp handshake),
//        vji_tck/tdi/ir_in/uir/cdr/sdr/udr/rti out, vji_tdo in.
module debug_slave_jtag_driver #(
   parameter int SR_WIDTH = 38,
   parameter int IR_WIDTH = 2,
   parameter int TCK_HALF = 2
) (
   input  logic                clk,
   input  logic                reset,
   debug_slave_jtag_driver_if.slave bus,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   localparam int HW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;
   localparam int BW = $clog2(SR_WIDTH + 1);
   localparam logic [HW-1:0] H_LAST = HW'(TCK_HALF - 1);
   localparam logic [BW-1:0] B_LAST = BW'(SR_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_UIR,
      S_CDR,
      S_SHIFT,
      S_UDR,
      S_RTI,
      S_DONE
   } state_t;

   state_t              state;
   logic [HW-1:0]       hcnt;
   logic [BW-1:0]       bcnt;
   logic [IR_WIDTH-1:0] ir_q;
   logic [SR_WIDTH-1:0] dr_q;
   logic [SR_WIDTH-1:0] cap_q;
   logic                half_end;
   logic                tick_end;
   logic                rise;
   logic                in_seq;

   assign half_end = (hcnt == H_LAST);
   // last clk of the high half closes a tick
   assign tick_end = half_end && vji_tck;
   // the edge that lifts tck is where tdo is sampled
   assign rise     = half_end && !vji_tck;
   assign in_seq   = (state == S_UIR) || (state == S_CDR) ||
                     (state == S_SHIFT) || (state == S_UDR) ||
                     (state == S_RTI);

   assign bus.cmd_ready = (state == S_IDLE) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         hcnt          <= '0;
         bcnt          <= '0;
         ir_q          <= '0;
         dr_q          <= '0;
         cap_q         <= '0;
         vji_tck       <= 1'b0;
         vji_tdi       <= 1'b0;
         vji_ir_in     <= '0;
         vji_uir       <= 1'b0;
         vji_cdr       <= 1'b0;
         vji_sdr       <= 1'b0;
         vji_udr       <= 1'b0;
         vji_rti       <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
      end else begin
         bus.rsp_valid <= 1'b0;

         // shared tck generator for every sequencing state
         if (in_seq) begin
            if (half_end) begin
               hcnt    <= '0;
               vji_tck <= ~vji_tck;
            end else begin
               hcnt <= hcnt + HW'(1);
            end
         end

         unique case (state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  ir_q  <= bus.cmd_ir;
                  dr_q  <= bus.cmd_data;
                  state <= S_LOAD;
               end
            end
            S_LOAD: begin
               hcnt      <= '0;
               vji_tck   <= 1'b0;
               vji_ir_in <= ir_q;
               vji_rti   <= 1'b0;
               vji_uir   <= 1'b1;
               state     <= S_UIR;
            end
            S_UIR: begin
               if (tick_end) begin
                  vji_uir <= 1'b0;
                  vji_cdr <= 1'b1;
                  state   <= S_CDR;
               end
            end
            S_CDR: begin
               if (tick_end) begin
                  vji_cdr <= 1'b0;
                  vji_sdr <= 1'b1;
                  vji_tdi <= dr_q[0];
                  dr_q    <= {1'b0, dr_q[SR_WIDTH-1:1]};
                  bcnt    <= '0;
                  state   <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               // MSB-in, shift right: first sample ends up at [0]
               if (rise) begin
                  cap_q <= {vji_tdo, cap_q[SR_WIDTH-1:1]};
               end
               if (tick_end) begin
                  if (bcnt == B_LAST) begin
                     vji_sdr <= 1'b0;
                     vji_udr <= 1'b1;
                     vji_tdi <= 1'b0;
                     state   <= S_UDR;
                  end else begin
                     bcnt    <= bcnt + BW'(1);
                     vji_tdi <= dr_q[0];
                     dr_q    <= {1'b0, dr_q[SR_WIDTH-1:1]};
                  end
               end
            end
            S_UDR: begin
               if (tick_end) begin
                  vji_udr <= 1'b0;
                  vji_rti <= 1'b1;
                  state   <= S_RTI;
               end
            end
            S_RTI: begin
               if (tick_end) begin
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_data  <= cap_q;
                  state         <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debug_slave_jtag_driver.sv
// Bench for debug_slave_jtag_driver: loopback and tdo-high slave models.
// Two instances: TCK_HALF=2 (u0) and TCK_HALF=1 (u1).
module tb_debug_slave_jtag_driver;

   localparam int SR  = 38;
   localparam int IRW = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail = 0;

   typedef struct {
      logic [SR-1:0] data;
      int            cyc;
   } exp_t;
   exp_t exp_q[$];

   debug_slave_jtag_driver_if #(.SR_WIDTH(SR), .IR_WIDTH(IRW)) if0 ();
   debug_slave_jtag_driver_if #(.SR_WIDTH(SR), .IR_WIDTH(IRW)) if1 ();

   logic           tck0, tdi0, tdo0, uir0, cdr0, sdr0, udr0, rti0;
   logic [IRW-1:0] ir0;
   logic           tck1, tdi1, tdo1, uir1, cdr1, sdr1, udr1, rti1;
   logic [IRW-1:0] ir1;

   // u0 slave: tdi looped to tdo; u1 slave: tdo high while shifting
   assign tdo0 = tdi0;
   assign tdo1 = sdr1;

   debug_slave_jtag_driver #(.SR_WIDTH(SR), .IR_WIDTH(IRW), .TCK_HALF(2)) u0 (
      .clk       (clk),
      .reset     (reset),
      .bus       (if0.slave),
      .vji_tck   (tck0),
      .vji_tdi   (tdi0),
      .vji_tdo   (tdo0),
      .vji_ir_in (ir0),
      .vji_uir   (uir0),
      .vji_cdr   (cdr0),
      .vji_sdr   (sdr0),
      .vji_udr   (udr0),
      .vji_rti   (rti0)
   );

   debug_slave_jtag_driver #(.SR_WIDTH(SR), .IR_WIDTH(IRW), .TCK_HALF(1)) u1 (
      .clk       (clk),
      .reset     (reset),
      .bus       (if1.slave),
      .vji_tck   (tck1),
      .vji_tdi   (tdi1),
      .vji_tdo   (tdo1),
      .vji_ir_in (ir1),
      .vji_uir   (uir1),
      .vji_cdr   (cdr1),
      .vji_sdr   (sdr1),
      .vji_udr   (udr1),
      .vji_rti   (rti1)
   );

   // continuous protocol checks
   logic           prev_rst = 1'b1;
   logic [IRW-1:0] prev_ir = '0;
   always @(negedge clk) begin
      if (!reset) begin
         n_checks++;
         if ($countones({uir0, cdr0, sdr0, udr0, rti0}) != 1) begin
            n_fail++;
            $display("FAIL onehot0 @%0d: got %b want one-hot", cyc,
                     {uir0, cdr0, sdr0, udr0, rti0});
         end
         n_checks++;
         if ($countones({uir1, cdr1, sdr1, udr1, rti1}) != 1) begin
            n_fail++;
            $display("FAIL onehot1 @%0d: got %b want one-hot", cyc,
                     {uir1, cdr1, sdr1, udr1, rti1});
         end
         n_checks++;
         if (!sdr0 && tdi0 !== 1'b0) begin
            n_fail++;
            $display("FAIL tdi_idle @%0d: got %b want 0", cyc, tdi0);
         end
         n_checks++;
         if (!prev_rst && ir0 !== prev_ir && !uir0) begin
            n_fail++;
            $display("FAIL ir_hold @%0d: got %b want %b", cyc, ir0, prev_ir);
         end
      end
      prev_rst = reset;
      prev_ir  = ir0;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      reset         = 1'b1;
      if0.cmd_valid = 1'b1;
      if0.cmd_ir    = 2'b11;
      if0.cmd_data  = '1;
      if1.cmd_valid = 1'b0;
      if1.cmd_ir    = '0;
      if1.cmd_data  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (if0.cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ready: got %b want 0", if0.cmd_ready);
      end
      n_checks++;
      if (rti0 !== 1'b1 || tck0 !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_rti_tck: got %b%b want 10", rti0, tck0);
      end
      n_checks++;
      if ({uir0, cdr0, sdr0, udr0, tdi0} !== 5'b0) begin
         n_fail++;
         $display("FAIL rst_flags: got %b want 00000",
                  {uir0, cdr0, sdr0, udr0, tdi0});
      end
      n_checks++;
      if (ir0 !== 2'b00 || if0.rsp_valid !== 1'b0 || if0.rsp_data !== '0) begin
         n_fail++;
         $display("FAIL rst_out: got ir=%b v=%b d=%h want 0 0 0",
                  ir0, if0.rsp_valid, if0.rsp_data);
      end
      @(posedge clk);
      #1;
      reset         = 1'b0;
      if0.cmd_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (if0.cmd_ready !== 1'b1 || if1.cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_release_ready: got %b%b want 11",
                  if0.cmd_ready, if1.cmd_ready);
      end
   endtask

   task automatic test_loopback();
      logic [SR-1:0] d;
      int   t_acc, rises, uirc, sdrc, tdi_bad, idx;
      bit   ok, got, ir_ok;
      logic pt;
      exp_t e;
      d = 38'h2A_5555_AAAA;
      @(posedge clk);
      #1;
      if0.cmd_valid = 1'b1;
      if0.cmd_ir    = 2'b01;
      if0.cmd_data  = d;
      ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = if0.cmd_ready;
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL lb_accept: got ready=0 want 1");
      end
      t_acc = cyc + 1;
      exp_q.push_back('{data: d, cyc: t_acc + 169});
      @(posedge clk);
      #1;
      if0.cmd_valid = 1'b0;
      rises = 0; uirc = 0; sdrc = 0; tdi_bad = 0;
      got = 0; ir_ok = 1; pt = 1'b0;
      for (int k = 0; k < 400 && !got; k++) begin
         @(negedge clk);
         if (uir0) begin
            uirc++;
            if (ir0 !== 2'b01) ir_ok = 0;
         end
         if (sdr0) begin
            sdrc++;
            if (tck0 && !pt) rises++;
            idx = tck0 ? rises - 1 : rises;
            if (idx < 0 || idx >= SR) tdi_bad++;
            else if (tdi0 !== d[idx]) tdi_bad++;
         end
         pt = tck0;
         if (if0.rsp_valid) got = 1;
      end
      n_checks++;
      if (!got || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL lb_rsp: got none want rsp_valid");
      end else begin
         e = exp_q.pop_front();
         n_checks++;
         if (if0.rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL lb_data: got %h want %h", if0.rsp_data, e.data);
         end
         n_checks++;
         if (cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL lb_latency: got %0d want %0d", cyc - t_acc, 169);
         end
      end
      n_checks++;
      if (uirc !== 4 || !ir_ok) begin
         n_fail++;
         $display("FAIL lb_uir: got %0d cycles ir_ok=%0d want 4 1", uirc, ir_ok);
      end
      n_checks++;
      if (sdrc !== 152 || rises !== 38) begin
         n_fail++;
         $display("FAIL lb_shift: got %0d cyc %0d ticks want 152 38",
                  sdrc, rises);
      end
      n_checks++;
      if (tdi_bad !== 0) begin
         n_fail++;
         $display("FAIL lb_tdi: got %0d bad cycles want 0", tdi_bad);
      end
      @(negedge clk);
      n_checks++;
      if (if0.rsp_valid !== 1'b0 || if0.rsp_data !== d || ir0 !== 2'b01) begin
         n_fail++;
         $display("FAIL lb_after: got v=%b d=%h ir=%b want 0 %h 01",
                  if0.rsp_valid, if0.rsp_data, ir0, d);
      end
   endtask

   task automatic test_ones();
      logic [SR-1:0] d;
      int   t_acc, r1, r2, nr;
      bit   ok, got;
      logic pt;
      exp_t e;
      d = 38'h15_0F0F_1234;
      @(posedge clk);
      #1;
      if1.cmd_valid = 1'b1;
      if1.cmd_ir    = 2'b10;
      if1.cmd_data  = d;
      ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = if1.cmd_ready;
      end
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL ones_accept: got ready=0 want 1");
      end
      t_acc = cyc + 1;
      exp_q.push_back('{data: '1, cyc: t_acc + 85});
      @(posedge clk);
      #1;
      if1.cmd_valid = 1'b0;
      got = 0; nr = 0; r1 = 0; r2 = 0; pt = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge clk);
         if (sdr1 && tck1 && !pt) begin
            nr++;
            if (nr == 1) r1 = cyc;
            if (nr == 2) r2 = cyc;
         end
         pt = tck1;
         if (if1.rsp_valid) got = 1;
      end
      n_checks++;
      if (!got || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL ones_rsp: got none want rsp_valid");
      end else begin
         e = exp_q.pop_front();
         n_checks++;
         if (if1.rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL ones_data: got %h want %h", if1.rsp_data, e.data);
         end
         n_checks++;
         if (cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL ones_latency: got %0d want 85", cyc - t_acc);
         end
      end
      n_checks++;
      if (r2 - r1 !== 2 || nr !== SR) begin
         n_fail++;
         $display("FAIL ones_period: got %0d cyc %0d ticks want 2 38",
                  r2 - r1, nr);
      end
   endtask

   task automatic test_back_to_back();
      logic [SR-1:0] a, b;
      int   t1, t2, t_done;
      bit   ok, got;
      exp_t e;
      a = 38'h01_2345_6789;
      b = 38'h3E_DCBA_9876;
      @(posedge clk);
      #1;
      if0.cmd_valid = 1'b1;
      if0.cmd_ir    = 2'b10;
      if0.cmd_data  = a;
      ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = if0.cmd_ready;
      end
      t1 = cyc + 1;
      exp_q.push_back('{data: a, cyc: t1 + 169});
      @(posedge clk);
      #1;
      if0.cmd_ir   = 2'b11;
      if0.cmd_data = b;
      got = 0; t_done = 0;
      for (int k = 0; k < 400 && !got; k++) begin
         @(negedge clk);
         n_checks++;
         if (if0.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy_ready @%0d: got 1 want 0", cyc);
         end
         if (if0.rsp_valid) begin
            got = 1;
            t_done = cyc;
         end
      end
      n_checks++;
      if (!got || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL b2b_rsp1: got none want rsp_valid");
      end else begin
         e = exp_q.pop_front();
         n_checks++;
         if (if0.rsp_data !== e.data || cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL b2b_rsp1_data: got %h @%0d want %h @%0d",
                     if0.rsp_data, cyc, e.data, e.cyc);
         end
      end
      ok = 0;
      for (int k = 0; k < 10 && !ok; k++) begin
         @(negedge clk);
         ok = if0.cmd_ready;
      end
      t2 = cyc + 1;
      n_checks++;
      if (t2 !== t_done + 2) begin
         n_fail++;
         $display("FAIL b2b_gap: got accept at done+%0d want done+2",
                  t2 - t_done);
      end
      n_checks++;
      if (ir0 !== 2'b10) begin
         n_fail++;
         $display("FAIL b2b_ir_hold: got %b want 10", ir0);
      end
      exp_q.push_back('{data: b, cyc: t2 + 169});
      @(posedge clk);
      #1;
      if0.cmd_valid = 1'b0;
      got = 0;
      for (int k = 0; k < 400 && !got; k++) begin
         @(negedge clk);
         if (if0.rsp_valid) got = 1;
      end
      n_checks++;
      if (!got || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL b2b_rsp2: got none want rsp_valid");
      end else begin
         e = exp_q.pop_front();
         n_checks++;
         if (if0.rsp_data !== e.data || cyc !== e.cyc || ir0 !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_rsp2_data: got %h @%0d ir=%b want %h @%0d ir=11",
                     if0.rsp_data, cyc, ir0, e.data, e.cyc);
         end
      end
   endtask

   task automatic test_reset_mid();
      int   rises;
      bit   ok, hit, saw;
      logic pt;
      logic [SR-1:0] held;
      held = if0.rsp_data;
      @(posedge clk);
      #1;
      if0.cmd_valid = 1'b1;
      if0.cmd_ir    = 2'b01;
      if0.cmd_data  = 38'h15_5555_5555;
      ok = 0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = if0.cmd_ready;
      end
      @(posedge clk);
      #1;
      if0.cmd_valid = 1'b0;
      rises = 0; hit = 0; pt = 1'b0;
      for (int k = 0; k < 200 && !hit; k++) begin
         @(negedge clk);
         if (sdr0 && tck0 && !pt) rises++;
         pt = tck0;
         if (sdr0 && !tck0 && rises == 10) hit = 1;
      end
      n_checks++;
      if (!hit) begin
         n_fail++;
         $display("FAIL mid_reach: got no shift tick 10 want reached");
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({tck0, tdi0, uir0, cdr0, sdr0, udr0, rti0} !== 7'b0000001 ||
          ir0 !== 2'b00 || if0.rsp_valid !== 1'b0 || if0.cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_vals: got %b ir=%b v=%b r=%b want 0000001 00 0 0",
                  {tck0, tdi0, uir0, cdr0, sdr0, udr0, rti0}, ir0,
                  if0.rsp_valid, if0.cmd_ready);
      end
      n_checks++;
      if (if0.rsp_data !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_data: got %h want 0 (was %h)",
                  if0.rsp_data, held);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (if0.cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_ready: got %b want 1", if0.cmd_ready);
      end
      saw = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (if0.rsp_valid || sdr0) saw = 1;
      end
      n_checks++;
      if (saw) begin
         n_fail++;
         $display("FAIL mid_dropped: got activity after reset want none");
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_ones();
      test_back_to_back();
      test_reset_mid();
      n_checks++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL sb_empty: got %0d pending want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
